// File: rtl/event_encoder_pkg.sv
// Shared types for the event encoder and its downstream register stage:
// FSM state encoding and the 2-bit event code values.
package event_encoder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      QUAL  = 2'b01,
      HIGH  = 2'b10,
      CLEAR = 2'b11
   } state_e;

   localparam logic [1:0] NONE   = 2'b00;
   localparam logic [1:0] RISE   = 2'b01;
   localparam logic [1:0] FALL   = 2'b10;
   localparam logic [1:0] GLITCH = 2'b11;

endpackage

// File: rtl/event_encoder_if.sv
// Event encoder signal bundle: raw event and clear request in, code/status/drop count out.
interface event_encoder_if;
   logic       ev_in;
   logic       clr_req;
   logic [1:0] count;
   logic       status;
   logic [3:0] drop_cnt;

   modport master (
      output ev_in, clr_req,
      input  count, status, drop_cnt
   );

   modport slave (
      input  ev_in, clr_req,
      output count, status, drop_cnt
   );
endinterface

// File: rtl/event_encoder_sat_counter4.sv
// 4-bit incrementer that sticks at 15 instead of wrapping; synchronous clear wins over inc.
module sat_counter4 (
   input  logic       clk,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] cnt
);

   logic [3:0] cnt_q, cnt_d;

   // next count: clear, else saturating increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 4'd0;
      end else if (inc && (cnt_q != 4'hF)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/event_encoder.sv
// Qualifies ev_in edges into one-cycle event codes, with a clear window that
// suppresses events and counts rises dropped while it is open.
//
// state | meaning
// IDLE  | waiting for a rise of ev_in
// QUAL  | ev_in high, counting samples toward HOLD
// HIGH  | rise qualified, waiting for the fall
// CLEAR | clear in progress, status high, events discarded
module event_encoder
   import event_encoder_pkg::*;
#(
   parameter int unsigned HOLD    = 2,
   parameter int unsigned CLR_LEN = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   event_encoder_if.slave bus
);

   localparam logic [3:0] HOLD_TC = 4'(HOLD);
   localparam logic [3:0] CLR_TC  = 4'(CLR_LEN);

   state_e     state_q, state_d;
   logic       ev_q, ev_d;
   logic [3:0] hold_q, hold_d;
   logic [3:0] clr_q, clr_d;
   logic [1:0] count_q, count_d;
   logic       status_q, status_d;
   logic       rise, fall, drop_inc;

   // next-state, hold/clear counters and registered outputs
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      clr_d    = clr_q;
      count_d  = NONE;
      status_d = 1'b0;
      ev_d     = bus.ev_in;
      rise     = bus.ev_in & ~ev_q;
      fall     = ~bus.ev_in & ev_q;
      drop_inc = (state_q == CLEAR) && rise;

      if (bus.clr_req) begin
         // clear beats any event decided in this cycle; the event is lost
         state_d  = CLEAR;
         clr_d    = CLR_TC;
         hold_d   = 4'd0;
         status_d = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (rise) begin
                  if (HOLD_TC == 4'd1) begin
                     state_d = HIGH;
                     count_d = RISE;
                  end else begin
                     state_d = QUAL;
                     hold_d  = 4'd1;
                  end
               end
            end
            QUAL: begin
               if (bus.ev_in) begin
                  if ((hold_q + 4'd1) == HOLD_TC) begin
                     state_d = HIGH;
                     count_d = RISE;
                     hold_d  = 4'd0;
                  end else begin
                     hold_d = hold_q + 4'd1;
                  end
               end else begin
                  state_d = IDLE;
                  count_d = GLITCH;
                  hold_d  = 4'd0;
               end
            end
            HIGH: begin
               if (fall) begin
                  state_d = IDLE;
                  count_d = FALL;
               end
            end
            CLEAR: begin
               // down-counter: terminal count 1 is the last cycle of the window
               if (clr_q <= 4'd1) begin
                  state_d = IDLE;
                  clr_d   = 4'd0;
               end else begin
                  clr_d    = clr_q - 4'd1;
                  status_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // state and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ev_q     <= 1'b0;
         hold_q   <= 4'd0;
         clr_q    <= 4'd0;
         count_q  <= NONE;
         status_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ev_q     <= ev_d;
         hold_q   <= hold_d;
         clr_q    <= clr_d;
         count_q  <= count_d;
         status_q <= status_d;
      end
   end

   sat_counter4 u_drop_cnt (
      .clk (clk),
      .clr (~rst_n),
      .inc (drop_inc),
      .cnt (bus.drop_cnt)
   );

   assign bus.count  = count_q;
   assign bus.status = status_q;

endmodule

// File: doc/event_encoder.md
EVENT_ENCODER -- requirements
Module: event_encoder

Interface
REQ-001 Parameter HOLD, default 2: consecutive high samples ev_in needs before a rise is qualified; legal range 1..15.
REQ-002 Parameter CLR_LEN, default 1: cycles status stays high per clear request; legal range 1..15.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-005 Port ev_in  input  1: raw event level, already synchronous to clk.
REQ-006 Port clr_req  input  1: clear request, level-sampled each cycle.
REQ-007 Port count  output  2: registered event code for the downstream register stage: 00 none, 01 qualified rise, 10 qualified fall, 11 glitch.
REQ-008 Port status  output  1: registered clear strobe for the downstream register stage; high = clear in progress.
REQ-009 Port drop_cnt  output  4: saturating count of rises dropped because status was high.

Function
REQ-010 State machine SHALL have exactly four states: IDLE, QUAL, HIGH, CLEAR.
REQ-011 A registered copy ev_q of ev_in; rise = ev_in & ~ev_q, fall = ~ev_in & ev_q.
REQ-012 IDLE: on rise, go to QUAL with hold counter = 1; if HOLD = 1, go directly to HIGH and emit count = 01 next cycle.
REQ-013 QUAL: each cycle with ev_in = 1 increments hold counter; when it reaches HOLD, go to HIGH and emit count = 01 for exactly one cycle.
REQ-014 QUAL: ev_in = 0 before HOLD is reached -> emit count = 11 for one cycle, return to IDLE.
REQ-015 HIGH: on fall, emit count = 10 for one cycle, return to IDLE; ev_in held high produces no further codes.
REQ-016 count SHALL be 00 in every cycle not named in REQ-012..015; every nonzero code lasts one cycle.
REQ-017 Latency: count code appears the cycle after the ev_in sample that decides it.
REQ-018 clr_req = 1 in any state -> next state CLEAR, status = 1 from the next cycle for exactly CLR_LEN cycles, count = 00 meanwhile.
REQ-019 clr_req has priority over any simultaneous rise, fall, or qualification; the event is discarded and no code is emitted.
REQ-020 clr_req re-asserted while in CLEAR restarts the CLR_LEN count.
REQ-021 A rise observed while in CLEAR increments drop_cnt, saturating at 15 (no wrap).
REQ-022 CLEAR exits to IDLE; if ev_in = 1 at exit, no rise is inferred until ev_in has gone low and high again.
REQ-023 drop_cnt clears only on reset.

Reset
REQ-024 rst_n = 0 at a clock edge SHALL force state IDLE, count = 00, status = 0, drop_cnt = 0, ev_q = 0, hold and clear counters = 0, regardless of state, including mid-QUAL or mid-CLEAR.
REQ-025 The first cycle after rst_n deasserts SHALL treat ev_in = 1 as a rise.

Structure
REQ-026 State encoding and the count code constants (NONE, RISE, FALL, GLITCH) SHALL live in a shared package used by this block and the downstream register stage.
REQ-027 One sub-module, sat_counter4 (4-bit saturating incrementer with sync clear), SHALL implement drop_cnt; all other logic SHALL be inline.

Verification
REQ-028 HOLD = 2: ev_in 0,1,1,1,0 -> count 00,00,00,01,00,10 with one-cycle codes at the required cycles.
REQ-029 HOLD = 3: ev_in 0,1,1,0 -> count 11 for one cycle and no 01; state returns to IDLE.
REQ-030 CLR_LEN = 2: clr_req pulse in the same cycle as the qualifying sample -> no 01; status high for exactly 2 cycles.
REQ-031 Issue 17 rises during a long CLEAR (clr_req held) -> drop_cnt = 15 and holds, no wrap to 0.
REQ-032 Assert rst_n = 0 mid-QUAL and mid-CLEAR -> all outputs 0 next cycle; the ev_in = 1 case of REQ-025 is exercised.
